// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding, flag layout.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_INV  = 4'd11;
    localparam logic [3:0] OP_NEG  = 4'd12;
    localparam logic [3:0] OP_STO  = 4'd13;
    localparam logic [3:0] OP_SWP  = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    // Assemble the flag nibble from its individual bits.
    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier. Operands are captured on start; one partial
// product is accumulated per cycle. The final iteration is exposed on the
// product output while last is high, so the owner can take the result on the
// same edge that completes the WIDTH-th iteration.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_active;

    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;

    // Partial product for the current multiplier bit.
    always_comb begin
        w_addend = '0;
        if (r_mplier[0]) begin
            w_addend = r_mcand;
        end else begin
            w_addend = '0;
        end
        w_acc_next = r_acc + w_addend;
    end

    // Operand capture on start, then one shift-add step per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, op_a};
            r_mplier <= op_b;
            r_acc    <= '0;
            r_cnt    <= CNT_INIT;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
                r_active <= 1'b0;
            end
        end
    end

    assign product = w_acc_next;
    assign last    = r_active && (r_cnt == CNT_ONE);

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with A/B/Y registers, status flags and a valid/busy/done
// handshake. Single-cycle ops complete on the accept edge; MUL runs through
// the shift-add sub-module and completes WIDTH edges later.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             op_valid,
    input  logic [3:0]       opcode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_y;
    logic [3:0]       r_flags;
    logic             r_done;
    logic             r_busy;

    logic             w_idle;
    logic             w_load;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_last;
    logic [2*WIDTH-1:0] w_prod;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_a_res;
    logic [WIDTH-1:0] w_b_res;
    logic [WIDTH-1:0] w_y_res;
    logic [WIDTH-1:0] w_flag_val;
    logic             w_c;
    logic             w_v;
    logic             w_upd_flags;
    logic [3:0]       w_flags_new;
    logic [3:0]       w_mul_flags;

    // Loads win over ops; nothing is taken while the multiplier is running.
    always_comb begin
        w_idle      = (r_state == ST_IDLE);
        w_load      = w_idle && (ld_a || ld_b);
        w_accept    = w_idle && op_valid && !(ld_a || ld_b);
        w_mul_start = w_accept && (opcode == OP_MUL);
    end

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (w_mul_start),
        .op_a    (r_a),
        .op_b    (r_b),
        .product (w_prod),
        .last    (w_mul_last)
    );

    // FSM next state: IDLE -> MUL on an accepted multiply, back when it ends.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mul_start) begin
                    w_state_next = ST_MUL;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (w_mul_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_MUL;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Single-cycle datapath: results and flag sources for every opcode.
    always_comb begin
        w_sum       = {1'b0, r_a} + {1'b0, r_b};
        w_diff      = r_a - r_b;
        w_a_res     = r_a;
        w_b_res     = r_b;
        w_y_res     = r_y;
        w_c         = 1'b0;
        w_v         = 1'b0;
        w_upd_flags = 1'b1;
        w_flag_val  = r_y;
        case (opcode)
            OP_ADD: begin
                w_y_res = w_sum[WIDTH-1:0];
                w_c     = w_sum[WIDTH];
                w_v     = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_y_res = w_diff;
                w_c     = (r_a < r_b);
                w_v     = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_CMP: begin
                w_y_res = {{(WIDTH-2){1'b0}}, (r_a > r_b), (r_a == r_b)};
                w_c     = (r_a < r_b);
            end
            OP_SHL: begin
                w_a_res = {r_a[WIDTH-2:0], 1'b0};
                w_c     = r_a[WIDTH-1];
            end
            OP_SHR: begin
                w_a_res = {1'b0, r_a[WIDTH-1:1]};
                w_c     = r_a[0];
            end
            OP_AND:  w_y_res = r_a & r_b;
            OP_OR:   w_y_res = r_a | r_b;
            OP_XOR:  w_y_res = r_a ^ r_b;
            OP_NAND: w_y_res = ~(r_a & r_b);
            OP_NOR:  w_y_res = ~(r_a | r_b);
            OP_XNOR: w_y_res = ~(r_a ^ r_b);
            OP_INV:  w_y_res = ~r_a;
            OP_NEG: begin
                w_y_res = ZERO - r_a;
                w_v     = (r_a == MIN_NEG);
            end
            OP_STO: begin
                w_a_res     = r_y;
                w_upd_flags = 1'b0;
            end
            OP_SWP: begin
                w_a_res     = r_b;
                w_b_res     = r_a;
                w_upd_flags = 1'b0;
            end
            default: begin
                // MUL: results arrive later from the multiplier.
                w_upd_flags = 1'b0;
            end
        endcase
        if ((opcode == OP_SHL) || (opcode == OP_SHR)) begin
            w_flag_val = w_a_res;
        end else begin
            w_flag_val = w_y_res;
        end
        w_flags_new = pack_flags(w_c, w_v, w_flag_val[WIDTH-1], (w_flag_val == ZERO));
        w_mul_flags = pack_flags(|w_prod[2*WIDTH-1:WIDTH], 1'b0, w_prod[WIDTH-1],
                                 (w_prod[WIDTH-1:0] == ZERO));
    end

    // Architectural state: loads, single-cycle results, multiply completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_flags <= 4'b0000;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (w_load) begin
                if (ld_a) begin
                    r_a <= din;
                end
                if (ld_b) begin
                    r_b <= din;
                end
            end else if (w_mul_start) begin
                r_busy <= 1'b1;
            end else if (w_accept) begin
                r_a    <= w_a_res;
                r_b    <= w_b_res;
                r_y    <= w_y_res;
                r_done <= 1'b1;
                if (w_upd_flags) begin
                    r_flags <= w_flags_new;
                end
            end else if (w_mul_last) begin
                r_y     <= w_prod[WIDTH-1:0];
                r_flags <= w_mul_flags;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end
    end

    assign a     = r_a;
    assign b     = r_b;
    assign y     = r_y;
    assign flags = r_flags;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=8) with hand-computed expectations.
module tb_seq_alu;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         ld_a;
    logic         ld_b;
    logic         op_valid;
    logic [3:0]   opcode;
    logic         busy;
    logic         done;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [3:0]   flags;

    int n_checks = 0;
    int n_pass   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .din      (din),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .op_valid (op_valid),
        .opcode   (opcode),
        .busy     (busy),
        .done     (done),
        .a        (a),
        .b        (b),
        .y        (y),
        .flags    (flags)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic la, input logic lb, input logic [W-1:0] v);
        ld_a = la;
        ld_b = lb;
        din  = v;
        tick();
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] o);
        op_valid = 1'b1;
        opcode   = o;
        tick();
        op_valid = 1'b0;
    endtask

    // Accept a MUL and count the samples with busy high (bounded).
    task automatic run_mul(output int cycles);
        do_op(4'd15);
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        reset    = 1'b1;
        din      = 8'h00;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        op_valid = 1'b0;
        opcode   = 4'd0;
        tick();
        tick();
        check("rst_a", a, 8'h00);
        check("rst_b", b, 8'h00);
        check("rst_y", y, 8'h00);
        check("rst_flags", flags, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        tick();

        // Basic ADD and done timing
        load(1'b1, 1'b0, 8'h0F);
        load(1'b0, 1'b1, 8'h01);
        check("ld_a", a, 8'h0F);
        check("ld_b", b, 8'h01);
        check("add_done_pre", done, 1'b0);
        do_op(4'd0);
        check("add_done", done, 1'b1);
        check("add_y", y, 8'h10);
        check("add_flags", flags, 4'b0000);
        tick();
        check("add_done_once", done, 1'b0);

        // Carry / overflow
        load(1'b1, 1'b0, 8'h7F);
        do_op(4'd0);
        check("ovf_y", y, 8'h80);
        check("ovf_flags", flags, 4'b0110);
        load(1'b1, 1'b0, 8'hFF);
        do_op(4'd0);
        check("carry_y", y, 8'h00);
        check("carry_flags", flags, 4'b1001);
        load(1'b1, 1'b0, 8'h80);
        do_op(4'd12);
        check("neg_y", y, 8'h80);
        check("neg_flags", flags, 4'b0110);

        // Dual load, then multiply
        load(1'b1, 1'b1, 8'h0D);
        check("dual_a", a, 8'h0D);
        check("dual_b", b, 8'h0D);
        load(1'b0, 1'b1, 8'h0B);
        run_mul(cyc);
        check("mul_busy_cycles", cyc, 8);
        check("mul_done", done, 1'b1);
        check("mul_y", y, 8'h8F);
        check("mul_flags", flags, 4'b0010);
        tick();
        check("mul_done_once", done, 1'b0);
        load(1'b1, 1'b0, 8'h20);
        load(1'b0, 1'b1, 8'h10);
        run_mul(cyc);
        check("mul2_y", y, 8'h00);
        check("mul2_flags", flags, 4'b1001);

        // Ops and loads during MUL are dropped
        load(1'b1, 1'b0, 8'h03);
        load(1'b0, 1'b1, 8'h04);
        do_op(4'd15);
        ndone    = 0;
        op_valid = 1'b1;
        opcode   = 4'd0;
        ld_a     = 1'b1;
        din      = 8'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            ndone += int'(done);
        end
        op_valid = 1'b0;
        ld_a     = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ndone += int'(done);
        end
        check("busy_ndone", ndone, 1);
        check("busy_a", a, 8'h03);
        check("busy_y", y, 8'h0C);
        check("busy_end", busy, 1'b0);

        // Load has priority over a same-cycle op
        ld_a     = 1'b1;
        din      = 8'h03;
        op_valid = 1'b1;
        opcode   = 4'd0;
        tick();
        ld_a     = 1'b0;
        op_valid = 1'b0;
        check("prio_done", done, 1'b0);
        check("prio_y", y, 8'h0C);

        // SUB with borrow
        load(1'b0, 1'b1, 8'h05);
        do_op(4'd1);
        check("sub_y", y, 8'hFE);
        check("sub_flags", flags, 4'b1010);

        // Register moves
        do_op(4'd14);
        check("swp_a", a, 8'h05);
        check("swp_b", b, 8'h03);
        check("swp_flags", flags, 4'b1010);
        check("swp_done", done, 1'b1);
        do_op(4'd0);
        check("add2_y", y, 8'h08);
        do_op(4'd13);
        check("sto_a", a, 8'h08);
        check("sto_flags", flags, 4'b0000);
        do_op(4'd3);
        check("shl_a", a, 8'h10);
        check("shl_y", y, 8'h08);
        check("shl_flags", flags, 4'b0000);

        // Reset in the middle of a MUL
        load(1'b1, 1'b0, 8'h02);
        load(1'b0, 1'b1, 8'h03);
        do_op(4'd15);
        tick();
        tick();
        tick();
        check("abort_busy_pre", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_a", a, 8'h00);
        check("abort_b", b, 8'h00);
        check("abort_y", y, 8'h00);
        check("abort_flags", flags, 4'b0000);
        check("abort_busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ndone += int'(done);
        end
        check("abort_ndone", ndone, 0);
        load(1'b1, 1'b0, 8'h21);
        load(1'b0, 1'b1, 8'h12);
        do_op(4'd0);
        check("post_done", done, 1'b1);
        check("post_y", y, 8'h33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with A/B/Y operand registers, a 4-bit opcode and a valid/busy/done handshake. It is the next generation of the 8-bit calculator datapath. It adds configurable width, status flags, explicit operand loading and a multi-cycle shift-add multiplier. It sits between the board-level input logic (switches and debounced buttons) and the seven-segment display path, which shows `y`.

## Interface
- `WIDTH`, 8: operand/result width; legal range ≥ 4.

- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `din`  in  WIDTH  load data for `ld_a` / `ld_b`.
- `ld_a`  in  1  load `din` into A.
- `ld_b`  in  1  load `din` into B.
- `op_valid`  in  1  execute `opcode` this cycle.
- `opcode`  in  4  operation select (see Operation).
- `busy`  out  1  multiply in progress; new ops and loads ignored.
- `done`  out  1  one-cycle pulse marking op completion.
- `a`, `b`, `y`  out  WIDTH each  register contents.
- `flags`  out  4  {carry, overflow, negative, zero}.

## Operation
- **Reset.** A, B, Y, flags, `busy`, `done` = 0; FSM = IDLE. Reset during MUL aborts it, with no `done`.
- **FSM states.**
  - IDLE → MUL on an accepted opcode 15.
  - MUL → IDLE after WIDTH iterations.
- **Acceptance.** An op is accepted only in IDLE with `op_valid`=1.
  - Ops presented while `busy` are dropped (no queue).
- **Loads.** Accepted only in IDLE. `ld_a` and `ld_b` can both be high and load the same `din`.
  - A load has priority over `op_valid` in the same cycle: the op is dropped and no `done` is produced.
- **Opcodes.** Y ← result unless noted. All arithmetic is modulo 2^WIDTH.
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 CMP: Y = {0…, A>B, A==B}, unsigned compare.
  - 3 SHL: A ← A<<1; Y unchanged.
  - 4 SHR: A ← A>>1 (logical); Y unchanged.
  - 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR, 10 XNOR: bitwise A op B.
  - 11 INV: ~A.
  - 12 NEG: −A.
  - 13 STO: A ← Y.
  - 14 SWP: A↔B.
  - 15 MUL: Y ← low WIDTH bits of A×B (unsigned).
- **Flags.** Updated by every op except STO and SWP, which leave flags unchanged.
  - zero: the written value is 0. For SHL/SHR this is the new A; otherwise it is Y.
  - negative: the MSB of that same value.
  - carry:
    - ADD: carry-out.
    - SUB/CMP: borrow (A<B).
    - SHL/SHR: the bit shifted out.
    - MUL: upper half of the product is nonzero.
    - All other ops: 0.
  - overflow:
    - ADD/SUB: signed overflow.
    - NEG: 1 when A = 100…0.
    - All other ops: 0.
- **MUL operands.** The multiplier captures A and B at accept. Later changes cannot occur because loads are blocked while `busy`.

## Timing
- **Single-cycle ops.** Accepted at edge k.
  - Registers and flags are updated at edge k.
  - `done`=1 for the cycle after edge k.
- **MUL.** Accepted at edge k.
  - `busy`=1 after edge k through edge k+WIDTH.
  - Y and flags are written at edge k+WIDTH.
  - `busy` drops and `done`=1 for the cycle after edge k+WIDTH.
  - Back-to-back MUL: the next one is accepted at edge k+WIDTH+1 at the earliest.
- **Outputs.** `done`, `busy` and `flags` are registered; no combinational input→output paths.
- **`done` rate.** Exactly one `done` per accepted op.

## Structure
- **Package `seq_alu_pkg`:**
  - opcode localparams (OP_ADD … OP_MUL);
  - FSM state encoding;
  - flag bit indices (FLAG_Z = 0, FLAG_N = 1, FLAG_V = 2, FLAG_C = 3).
- **Sub-module `seq_alu_mul`:** WIDTH-parameterised shift-add multiplier.
  - Inputs: `clock`, `reset`, `start`, operands.
  - Outputs: a 2·WIDTH-bit product and a `last` strobe.
  - Iteration counter width: $clog2(WIDTH+1).
- **Top level:** the single-cycle ops are a combinational case on `opcode`.

## Test plan
All scenarios use WIDTH=8.

1. Load A=0x0F, B=0x01, ADD → Y=0x10, flags 0000. `done` is high exactly one cycle after the accept edge.
2. Carry and overflow cases:
   - A=0x7F, B=0x01, ADD → Y=0x80, V=1, N=1, C=0.
   - A=0xFF, B=0x01, ADD → Y=0x00, Z=1, C=1.
   - A=0x80, NEG → Y=0x80, V=1.
3. Multiply cases:
   - A=0x0D, B=0x0B, MUL → `busy` high for 8 cycles, then Y=0x8F, C=0.
   - A=0x20, B=0x10, MUL → Y=0x00, Z=1, C=1.
4. During MUL, assert `op_valid` (ADD) and `ld_a` (din=0x55) → both ignored. A stays unchanged, Y = MUL result, one `done` only.
5. Register moves:
   - A=0x03, B=0x05, SWP → A=0x05, B=0x03, flags unchanged.
   - Then ADD, then STO → A=0x08.
   - Then SHL → A=0x10, C=0.
6. Assert `reset` at cycle 4 of a MUL → all outputs 0 immediately, `busy`=0, no `done`. A following ADD of loaded values works normally.
